// File: rtl/grf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grf_pkg
//  Description : Shared types and constants for the GRF write-back path.
//  Revision    : 1.0 - initial release
// ============================================================================
package grf_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // One GRF write: destination, data and the PC recorded in the write log
    typedef struct packed {
        logic [REG_W-1:0]  a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : MDU result FIFO. Each entry carries a GRF write plus a squash
//                flag. The flag can be set on every entry whose address
//                matches, so a younger in-order write can cancel it.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import grf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wb_req_t          push_req,
    input  logic             push_squash,
    input  logic             pop,
    input  logic             squash_en,
    input  logic [REG_W-1:0] squash_a3,
    output wb_req_t          head_req,
    output logic             head_squash,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    wb_req_t          r_mem [DEPTH];
    logic             r_sq  [DEPTH];
    logic             w_push;
    logic             w_pop;

    // A push while full or a pop while empty is ignored
    assign w_push      = push && !full;
    assign w_pop       = pop && !empty;
    assign empty       = (r_count == '0);
    assign full        = (r_count == (PTR_W+1)'(DEPTH));
    assign head_req    = r_mem[r_rptr];
    assign head_squash = r_sq[r_rptr];

    // Read/write pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage. It needs no reset because occupancy gates its use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_req;
        end
    end

    // Per-entry squash flags. A push loads its own flag. A matching address squashes a resident entry.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        // Squash state of slot i
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sq[i] <= 1'b0;
            end else if (w_push && (r_wptr == PTR_W'(i))) begin
                r_sq[i] <= push_squash;
            end else if (squash_en && (r_mem[i].a3 == squash_a3)) begin
                r_sq[i] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : grf_wb_arbiter
//  Description : Shares the single GRF write port between the in-order W stage
//                and buffered MDU results. The block also keeps the
//                pending-write busy mask and bounds how long the MDU can be
//                starved.
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_wb_arbiter
    import grf_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_a3,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,
    output logic        pipe_stall,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_a3,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_a3,
    input  logic [31:0] mdu_wd,
    input  logic [31:0] mdu_pc,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic [31:0] busy_mask
);

    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    wb_req_t            w_head;
    wb_req_t            w_push_req;
    logic               w_head_sq;
    logic               w_head_valid;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_push_sq;
    logic               w_pop;
    logic               w_pipe_req;
    logic               w_pipe_commit;
    logic               w_age_inc;
    logic [31:0]        w_busy_set;
    logic [31:0]        w_busy_clr;
    logic [AGE_W-1:0]   r_age;
    logic               r_pipe_stall;
    logic               r_active;
    logic [31:0]        r_busy;

    // The reset input gates the pipeline request so the port stays idle while reset is held
    assign w_pipe_req   = reset && pipe_we && (pipe_a3 != REG_ZERO);
    assign w_head_valid = !w_empty;
    assign mdu_ready    = r_active && !w_full;
    assign w_push       = mdu_valid && mdu_ready;
    assign pipe_stall   = r_pipe_stall;
    assign busy_mask    = r_busy;

    assign w_push_req.a3 = mdu_a3;
    assign w_push_req.wd = mdu_wd;
    assign w_push_req.pc = mdu_pc;

    // Results to $0, and results overtaken by a pipeline write committing this cycle, enter pre-squashed
    assign w_push_sq = (mdu_a3 == REG_ZERO) || (w_pipe_commit && (pipe_a3 == mdu_a3));

    wb_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (w_push),
        .push_req    (w_push_req),
        .push_squash (w_push_sq),
        .pop         (w_pop),
        .squash_en   (w_pipe_commit),
        .squash_a3   (pipe_a3),
        .head_req    (w_head),
        .head_squash (w_head_sq),
        .empty       (w_empty),
        .full        (w_full)
    );

    // Port grant: a forced head write, then the pipeline, then the FIFO. A squashed head always drains silently.
    always_comb begin
        grf_we        = 1'b0;
        grf_a3        = '0;
        grf_wd        = '0;
        grf_pc        = '0;
        w_pop         = 1'b0;
        w_pipe_commit = 1'b0;
        if (r_pipe_stall) begin
            if (w_head_valid) begin
                w_pop = 1'b1;
                if (!w_head_sq) begin
                    grf_we = 1'b1;
                    grf_a3 = w_head.a3;
                    grf_wd = w_head.wd;
                    grf_pc = w_head.pc;
                end
            end
        end else if (w_pipe_req) begin
            w_pipe_commit = 1'b1;
            grf_we        = 1'b1;
            grf_a3        = pipe_a3;
            grf_wd        = pipe_wd;
            grf_pc        = pipe_pc;
            if (w_head_valid && w_head_sq) begin
                w_pop = 1'b1;
            end
        end else if (w_head_valid) begin
            w_pop = 1'b1;
            if (!w_head_sq) begin
                grf_we = 1'b1;
                grf_a3 = w_head.a3;
                grf_wd = w_head.wd;
                grf_pc = w_head.pc;
            end
        end
    end

    // Busy-mask updates: an issue sets its bit; a head leaving the FIFO or a squashed push clears its bit
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (mdu_issue && (mdu_issue_a3 != REG_ZERO)) begin
            w_busy_set[mdu_issue_a3] = 1'b1;
        end
        if (w_pop) begin
            w_busy_clr[w_head.a3] = 1'b1;
        end
        if (w_push && w_push_sq) begin
            w_busy_clr[mdu_a3] = 1'b1;
        end
    end

    // Busy-mask register. When a bit is set and cleared in the same cycle, the set wins. Bit 0 is never busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
        end
    end

    // A live head that is denied the port ages by one cycle
    assign w_age_inc = w_head_valid && !w_head_sq && !w_pop;

    // Starvation counter. The denial that brings age to MAX_WAIT arms a one-cycle stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_age        <= '0;
            r_pipe_stall <= 1'b0;
        end else begin
            r_pipe_stall <= w_age_inc && (r_age == AGE_W'(MAX_WAIT - 1));
            if (w_pop) begin
                r_age <= '0;
            end else if (w_age_inc && (r_age != AGE_W'(MAX_WAIT))) begin
                r_age <= r_age + 1'b1;
            end
        end
    end

    // Holds mdu_ready low until the first clock after reset releases
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Issuing to a register that still has an MDU write outstanding is illegal, unless that write retires this cycle
    a_no_reissue: assert property (@(posedge clk) disable iff (!reset)
        !(mdu_issue && (mdu_issue_a3 != REG_ZERO) && r_busy[mdu_issue_a3] && !w_busy_clr[mdu_issue_a3]));

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grf_wb_arbiter
//  Description : Scoreboard bench for grf_wb_arbiter. Each GRF write the
//                stimulus implies is queued, and the monitor retires queued
//                writes against the port in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_wb_arbiter;
    import grf_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pipe_we, mdu_issue, mdu_valid;
    logic [4:0]  pipe_a3, mdu_issue_a3, mdu_a3;
    logic [31:0] pipe_wd, pipe_pc, mdu_wd, mdu_pc;
    logic        pipe_stall, mdu_ready, grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc, busy_mask;

    int          n_checks = 0;
    int          n_errors = 0;
    wb_req_t     exp_q [$];
    logic [31:0] rf [32];
    int          n;

    grf_wb_arbiter #(
        .DEPTH        (2),
        .MAX_WAIT     (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_we      (pipe_we),
        .pipe_a3      (pipe_a3),
        .pipe_wd      (pipe_wd),
        .pipe_pc      (pipe_pc),
        .pipe_stall   (pipe_stall),
        .mdu_issue    (mdu_issue),
        .mdu_issue_a3 (mdu_issue_a3),
        .mdu_valid    (mdu_valid),
        .mdu_ready    (mdu_ready),
        .mdu_a3       (mdu_a3),
        .mdu_wd       (mdu_wd),
        .mdu_pc       (mdu_pc),
        .grf_we       (grf_we),
        .grf_a3       (grf_a3),
        .grf_wd       (grf_wd),
        .grf_pc       (grf_pc),
        .busy_mask    (busy_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pipe_we = 1'b0; pipe_a3 = '0; pipe_wd = '0; pipe_pc = '0;
        mdu_issue = 1'b0; mdu_issue_a3 = '0;
        mdu_valid = 1'b0; mdu_a3 = '0; mdu_wd = '0; mdu_pc = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_w(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        wb_req_t e;
        e.a3 = a3; e.wd = wd; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic pipe(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        pipe_we = 1'b1; pipe_a3 = a3; pipe_wd = wd; pipe_pc = pc;
    endtask

    task automatic mdu(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        mdu_valid = 1'b1; mdu_a3 = a3; mdu_wd = wd; mdu_pc = pc;
    endtask

    task automatic issue(input logic [4:0] a3);
        mdu_issue = 1'b1; mdu_issue_a3 = a3;
        step();
        mdu_issue = 1'b0;
    endtask

    // Monitor: every GRF write must be the oldest outstanding expected write
    always @(negedge clk) begin
        if (grf_we) begin
            if (exp_q.size() == 0) begin
                check("grf_unexpected_write", {grf_a3, grf_wd, grf_pc}, 69'd0);
            end else begin
                check("grf_write", {grf_a3, grf_wd, grf_pc},
                      {exp_q[0].a3, exp_q[0].wd, exp_q[0].pc});
                void'(exp_q.pop_front());
                rf[grf_a3] <= grf_wd;
            end
        end
    end

    initial begin
        idle();
        // Reset state, with the pipeline driving a write that must stay blocked
        pipe(5'd3, 32'h33, 32'h100);
        step(); step();
        check("rst_grf_we", grf_we, 1'b0);
        check("rst_busy", busy_mask, 32'd0);
        check("rst_ready", mdu_ready, 1'b0);
        check("rst_stall", pipe_stall, 1'b0);
        idle();
        reset = 1'b1;
        step();
        check("post_rst_ready", mdu_ready, 1'b1);

        // Single MDU result with an idle pipeline
        issue(5'd8);
        check("t1_busy_set", busy_mask, 32'h0000_0100);
        mdu(5'd8, 32'h1234, 32'h3000);
        exp_w(5'd8, 32'h1234, 32'h3000);
        @(negedge clk);
        check("t1_no_same_cycle", grf_we, 1'b0);
        step();
        mdu_valid = 1'b0;
        @(negedge clk);
        check("t1_we", grf_we, 1'b1);
        check("t1_a3", grf_a3, 5'd8);
        step();
        @(negedge clk);
        check("t1_busy_clr", busy_mask, 32'd0);

        // Starvation: continuous pipeline writes to $9 against one MDU entry for $10
        step();
        issue(5'd10);
        n = 0;
        for (int j = 0; j < 7; j++) begin
            pipe(5'd9, 32'h900 + n, 32'h2000 + 4 * n);
            mdu_valid = (j == 0);
            mdu_a3 = 5'd10; mdu_wd = 32'hA10; mdu_pc = 32'h3010;
            if (j == 5) exp_w(5'd10, 32'hA10, 32'h3010);
            else        exp_w(5'd9, 32'h900 + n, 32'h2000 + 4 * n);
            @(negedge clk);
            check("t2_stall", pipe_stall, (j == 5));
            if (j != 5) n++;
            step();
        end
        idle();
        @(negedge clk);
        check("t2_busy_clr", busy_mask, 32'd0);
        check("t2_stall_off", pipe_stall, 1'b0);
        step();

        // WAW: queued MDU write to $5 is overtaken by the pipeline
        issue(5'd5);
        pipe(5'd6, 32'h66, 32'h2100);
        exp_w(5'd6, 32'h66, 32'h2100);
        mdu(5'd5, 32'h5555, 32'h3050);
        step();
        mdu_valid = 1'b0;
        pipe(5'd5, 32'hAAAA, 32'h2104);
        exp_w(5'd5, 32'hAAAA, 32'h2104);
        step();
        idle();
        @(negedge clk);
        check("t3_silent_pop", grf_we, 1'b0);
        step();
        @(negedge clk);
        check("t3_busy_clr", busy_mask, 32'd0);
        check("t3_rf5", rf[5], 32'hAAAA);

        // WAW at push time: the pipeline writes $7 in the same cycle the MDU result for $7 arrives
        step();
        issue(5'd7);
        pipe(5'd7, 32'h77, 32'h2200);
        exp_w(5'd7, 32'h77, 32'h2200);
        mdu(5'd7, 32'h7777, 32'h3070);
        step();
        idle();
        @(negedge clk);
        check("t3b_no_write", grf_we, 1'b0);
        check("t3b_busy_clr", busy_mask, 32'd0);
        step();

        // Back-pressure: fill the FIFO while the pipeline owns the port
        issue(5'd12); issue(5'd13); issue(5'd14);
        n = 0;
        for (int j = 0; j < 7; j++) begin
            pipe(5'd11, 32'hB00 + n, 32'h2300 + 4 * n);
            mdu_valid = (j != 5) || 1'b1;
            case (j)
                0:       mdu(5'd12, 32'hC12, 32'h3120);
                1:       mdu(5'd13, 32'hC13, 32'h3130);
                default: mdu(5'd14, 32'hC14, 32'h3140);
            endcase
            if (j == 5) exp_w(5'd12, 32'hC12, 32'h3120);
            else        exp_w(5'd11, 32'hB00 + n, 32'h2300 + 4 * n);
            @(negedge clk);
            check("t4_ready", mdu_ready, (j < 2) || (j == 6));
            check("t4_stall", pipe_stall, (j == 5));
            if (j != 5) n++;
            step();
        end
        idle();
        exp_w(5'd13, 32'hC13, 32'h3130);
        exp_w(5'd14, 32'hC14, 32'h3140);
        @(negedge clk);
        check("t4_drain13", grf_a3, 5'd13);
        step();
        @(negedge clk);
        check("t4_drain14", grf_a3, 5'd14);
        step();
        @(negedge clk);
        check("t4_busy_clr", busy_mask, 32'd0);
        step();

        // Writes to $0 from both sources never reach the port
        pipe(5'd0, 32'hDEAD, 32'h2400);
        mdu(5'd0, 32'hBEEF, 32'h3400);
        mdu_issue = 1'b1; mdu_issue_a3 = 5'd0;
        @(negedge clk);
        check("t5_we_pipe0", grf_we, 1'b0);
        step();
        idle();
        @(negedge clk);
        check("t5_we_mdu0", grf_we, 1'b0);
        check("t5_busy", busy_mask, 32'd0);
        step();

        // Asynchronous reset with two entries queued and a stall armed
        issue(5'd22); issue(5'd23);
        for (int j = 0; j < 5; j++) begin
            pipe(5'd21, 32'h2100 + j, 32'h2500 + 4 * j);
            exp_w(5'd21, 32'h2100 + j, 32'h2500 + 4 * j);
            mdu_valid = (j < 2);
            mdu_a3 = (j == 0) ? 5'd22 : 5'd23;
            mdu_wd = 32'hD00 + j; mdu_pc = 32'h3500 + j;
            step();
        end
        mdu_valid = 1'b0;
        check("t6_stall_armed", pipe_stall, 1'b1);
        check("t6_busy_armed", busy_mask, 32'h00C0_0000);
        reset = 1'b0;
        #1;
        check("t6_rst_we", grf_we, 1'b0);
        check("t6_rst_a3wd", {grf_a3, grf_wd, grf_pc}, 69'd0);
        check("t6_rst_stall", pipe_stall, 1'b0);
        check("t6_rst_ready", mdu_ready, 1'b0);
        check("t6_rst_busy", busy_mask, 32'd0);
        idle();
        step(); step();
        reset = 1'b1;
        step();
        check("t6_ready", mdu_ready, 1'b1);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("t6_no_stale", grf_we, 1'b0);
            step();
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
